mem_arbiter: RTL and testbench

Merges the pipeline's instruction-fetch port and data-memory port onto a single external memory bus. It sits directly downstream of the pipeline: it consumes `imem_*` and `dmem_*` requests and returns fetch data and load data. Data accesses have priority, and grants alternate when both ports are waiting. A watchdog terminates hung bus cycles and raises a sticky error flag.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one external memory bus between the instruction-fetch and data ports.
// Data goes first, grants alternate under contention, and a watchdog aborts hung bus cycles.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] imem_addr,
  input  logic        imem_addr_valid,
  output logic [63:0] imem_data,
  output logic        imem_data_valid,
  input  logic [63:0] dmem_addr,
  input  logic [63:0] dmem_dout,
  input  logic [1:0]  dmem_write_width,
  input  logic        dmem_rstrobe,
  input  logic        dmem_wstrobe,
  output logic [63:0] dmem_din,
  output logic        dmem_cycle_complete,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [1:0]  mem_width,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             src_data, src_data_nxt;
  logic             last_data, last_data_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [63:0]      addr_nxt, wdata_nxt, idata_nxt, din_nxt, rdata_cap;
  logic [1:0]       width_nxt;
  logic             we_nxt, req_nxt, err_nxt, cc_nxt;
  logic             fetch_done, fetch_done_nxt;
  logic             data_pend, grant_data, finish;

  // Completion of a fetch is only reported if the pipeline still wants that address.
  assign imem_data_valid = fetch_done & imem_addr_valid & (imem_addr == mem_addr);

  always_comb begin
    state_nxt      = state;
    src_data_nxt   = src_data;
    last_data_nxt  = last_data;
    cnt_nxt        = cnt;
    addr_nxt       = mem_addr;
    wdata_nxt      = mem_wdata;
    width_nxt      = mem_width;
    we_nxt         = mem_we;
    req_nxt        = mem_req;
    idata_nxt      = imem_data;
    din_nxt        = dmem_din;
    err_nxt        = bus_error;
    cc_nxt         = 1'b0;
    fetch_done_nxt = 1'b0;
    finish         = 1'b0;
    rdata_cap      = '0;
    cnt_inc        = cnt + CNT_W'(1);
    data_pend      = dmem_rstrobe | dmem_wstrobe;
    grant_data     = data_pend & ~(imem_addr_valid & last_data);

    case (state)
      IDLE: begin
        if (data_pend | imem_addr_valid) begin
          state_nxt     = BUS;
          req_nxt       = 1'b1;
          cnt_nxt       = '0;
          src_data_nxt  = grant_data;
          last_data_nxt = grant_data;
          if (grant_data) begin
            addr_nxt  = dmem_addr;
            wdata_nxt = dmem_dout;
            width_nxt = dmem_write_width;
            we_nxt    = dmem_wstrobe;
          end else begin
            addr_nxt  = imem_addr;
            wdata_nxt = '0;
            width_nxt = 2'd3;
            we_nxt    = 1'b0;
          end
        end
      end
      BUS: begin
        if (mem_ack) begin
          finish    = 1'b1;
          rdata_cap = mem_rdata;
        end else begin
          cnt_nxt = cnt_inc;
          if (WD_EN && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
            finish  = 1'b1;
            err_nxt = 1'b1;
          end
        end
        // An aborted cycle returns zero data to whichever port owned the bus.
        if (finish) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          if (src_data) begin
            cc_nxt = 1'b1;
            if (!mem_we) din_nxt = rdata_cap;
          end else begin
            idata_nxt      = rdata_cap;
            fetch_done_nxt = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      src_data            <= 1'b0;
      last_data           <= 1'b0;
      cnt                 <= '0;
      mem_addr            <= '0;
      mem_wdata           <= '0;
      mem_width           <= '0;
      mem_we              <= 1'b0;
      mem_req             <= 1'b0;
      imem_data           <= '0;
      dmem_din            <= '0;
      bus_error           <= 1'b0;
      dmem_cycle_complete <= 1'b0;
      fetch_done          <= 1'b0;
    end else begin
      state               <= state_nxt;
      src_data            <= src_data_nxt;
      last_data           <= last_data_nxt;
      cnt                 <= cnt_nxt;
      mem_addr            <= addr_nxt;
      mem_wdata           <= wdata_nxt;
      mem_width           <= width_nxt;
      mem_we              <= we_nxt;
      mem_req             <= req_nxt;
      imem_data           <= idata_nxt;
      dmem_din            <= din_nxt;
      bus_error           <= err_nxt;
      dmem_cycle_complete <= cc_nxt;
      fetch_done          <= fetch_done_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed scenarios, and a
// second instance with a short watchdog for the timeout scenario.
module tb_mem_arbiter;

  localparam int unsigned T_MAIN  = 255;
  localparam int unsigned T_SHORT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] imem_addr, imem_data, dmem_addr, dmem_dout, dmem_din;
  logic        imem_addr_valid, imem_data_valid, dmem_rstrobe, dmem_wstrobe, dmem_cycle_complete;
  logic [1:0]  dmem_write_width, mem_width;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_req, mem_ack, bus_error;

  logic [63:0] t_iaddr, t_idata, t_daddr, t_dout, t_din, t_maddr, t_mwdata, t_rdata;
  logic        t_ivalid, t_ivld, t_rstrobe, t_wstrobe, t_cc, t_mwe, t_req, t_ack, t_err;
  logic [1:0]  t_width, t_mwidth;

  mem_arbiter #(.TIMEOUT_CYCLES(T_MAIN)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid),
    .dmem_addr(dmem_addr), .dmem_dout(dmem_dout), .dmem_write_width(dmem_write_width),
    .dmem_rstrobe(dmem_rstrobe), .dmem_wstrobe(dmem_wstrobe),
    .dmem_din(dmem_din), .dmem_cycle_complete(dmem_cycle_complete),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width), .mem_we(mem_we),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  mem_arbiter #(.TIMEOUT_CYCLES(T_SHORT)) dut_t (
    .clk(clk), .rst(rst),
    .imem_addr(t_iaddr), .imem_addr_valid(t_ivalid),
    .imem_data(t_idata), .imem_data_valid(t_ivld),
    .dmem_addr(t_daddr), .dmem_dout(t_dout), .dmem_write_width(t_width),
    .dmem_rstrobe(t_rstrobe), .dmem_wstrobe(t_wstrobe),
    .dmem_din(t_din), .dmem_cycle_complete(t_cc),
    .mem_addr(t_maddr), .mem_wdata(t_mwdata), .mem_width(t_mwidth), .mem_we(t_mwe),
    .mem_req(t_req), .mem_rdata(t_rdata), .mem_ack(t_ack), .bus_error(t_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h100) return 64'hA5A5_A5A5_A5A5_A5A5;
    return {~a[31:0], a[31:0]};
  endfunction

  // Memory responder for the main instance: acks after ack_delay request cycles.
  int ack_delay = 0;
  int req_age = 0;
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      mem_ack   = (req_age == ack_delay);
      mem_rdata = mem_ack ? mem_fn(mem_addr) : 64'h0;
      req_age++;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 64'h0;
      req_age   = 0;
    end
  end

  // Transaction model: one bus transaction at a time, a report cycle, then a quiet cycle.
  bit          m_busy, m_done, m_last_data, m_src_data;
  int          m_age;
  logic [63:0] m_result;
  logic        e_req, e_we, e_cc, e_fdone, e_err;
  logic [63:0] e_addr, e_wdata, e_idata, e_din;
  logic [1:0]  e_width;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_last_data = 0; m_src_data = 0; m_age = 0;
      e_req = 0; e_we = 0; e_cc = 0; e_fdone = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_idata = '0; e_din = '0; e_width = '0;
    end else begin
      e_cc = 0;
      e_fdone = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        if (mem_ack || (T_MAIN != 0 && m_age + 1 == T_MAIN)) begin
          m_result = mem_ack ? mem_fn(e_addr) : 64'h0;
          if (!mem_ack) e_err = 1;
          m_busy = 0;
          m_done = 1;
          e_req  = 0;
          if (m_src_data) begin
            e_cc = 1;
            if (!e_we) e_din = m_result;
          end else begin
            e_idata = m_result;
            e_fdone = 1;
          end
        end else begin
          m_age++;
        end
      end else if (dmem_rstrobe || dmem_wstrobe || imem_addr_valid) begin
        m_src_data  = (dmem_rstrobe || dmem_wstrobe) && !(imem_addr_valid && m_last_data);
        m_last_data = m_src_data;
        m_busy = 1;
        m_age  = 0;
        e_req  = 1;
        if (m_src_data) begin
          e_addr = dmem_addr; e_wdata = dmem_dout; e_width = dmem_write_width; e_we = dmem_wstrobe;
        end else begin
          e_addr = imem_addr; e_width = 2'd3; e_we = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_mem_req", mem_req, e_req);
      if (e_req) begin
        check("cyc_mem_addr", mem_addr, e_addr);
        check("cyc_mem_we", mem_we, e_we);
        check("cyc_mem_width", mem_width, e_width);
        if (e_we) check("cyc_mem_wdata", mem_wdata, e_wdata);
      end
      check("cyc_dmem_cc", dmem_cycle_complete, e_cc);
      check("cyc_imem_valid", imem_data_valid, e_fdone && imem_addr_valid && (imem_addr == e_addr));
      check("cyc_imem_data", imem_data, e_idata);
      check("cyc_dmem_din", dmem_din, e_din);
      check("cyc_bus_error", bus_error, e_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 50) begin tick(); n++; end
    check(name, mem_req, 1'b1);
  endtask

  task automatic wait_req_low(input string name);
    int n = 0;
    while (mem_req && n < 50) begin tick(); n++; end
    check(name, mem_req, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1);
  end

  logic [63:0] contend_addrs [4];
  int n_cyc;

  initial begin
    contend_addrs = '{64'h2000, 64'h400, 64'h2000, 64'h400};
    imem_addr = '0; imem_addr_valid = 0; dmem_addr = '0; dmem_dout = '0;
    dmem_write_width = '0; dmem_rstrobe = 0; dmem_wstrobe = 0;
    mem_ack = 0; mem_rdata = '0;
    t_iaddr = '0; t_ivalid = 0; t_daddr = '0; t_dout = '0; t_width = 2'd3;
    t_rstrobe = 0; t_wstrobe = 0; t_rdata = '0; t_ack = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_imem_data", imem_data, 64'h0);
    check("reset_dmem_din", dmem_din, 64'h0);
    check("reset_bus_error", bus_error, 1'b0);
    rst = 0;
    tick();

    // Single fetch with zero-wait memory.
    imem_addr = 64'h100; imem_addr_valid = 1;
    tick();
    check("fetch_req", mem_req, 1'b1);
    check("fetch_addr", mem_addr, 64'h100);
    check("fetch_width", mem_width, 2'd3);
    check("fetch_we", mem_we, 1'b0);
    tick();
    check("fetch_pulse", imem_data_valid, 1'b1);
    check("fetch_data", imem_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check("fetch_req_dropped", mem_req, 1'b0);
    tick();
    imem_addr_valid = 0;
    tick(); tick();

    // Contention from reset: data, instr, data, instr.
    rst = 1;
    tick();
    rst = 0;
    dmem_addr = 64'h2000; dmem_write_width = 2'd3; dmem_rstrobe = 1;
    imem_addr = 64'h400; imem_addr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("contend_grant%0d", i));
      check($sformatf("contend_addr%0d", i), mem_addr, contend_addrs[i]);
      wait_req_low($sformatf("contend_end%0d", i));
    end
    check("contend_last_pulse", imem_data_valid, 1'b1);
    check("contend_din", dmem_din, 64'hFFFF_DFFF_0000_2000);
    tick();
    dmem_rstrobe = 0; imem_addr_valid = 0;
    tick();

    // Half-word store leaves the load result alone.
    dmem_wstrobe = 1; dmem_write_width = 2'd1; dmem_addr = 64'h31; dmem_dout = 64'hBEEF;
    tick();
    check("store_we", mem_we, 1'b1);
    check("store_width", mem_width, 2'd1);
    check("store_wdata", mem_wdata, 64'hBEEF);
    check("store_addr", mem_addr, 64'h31);
    tick();
    check("store_pulse", dmem_cycle_complete, 1'b1);
    check("store_din_kept", dmem_din, 64'hFFFF_DFFF_0000_2000);
    tick();
    dmem_wstrobe = 0;
    tick();

    // Read and write strobes together behave as a store.
    dmem_rstrobe = 1; dmem_wstrobe = 1; dmem_addr = 64'h40; dmem_write_width = 2'd3;
    dmem_dout = 64'h1122_3344_5566_7788;
    tick();
    check("both_we", mem_we, 1'b1);
    check("both_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    tick();
    check("both_pulse", dmem_cycle_complete, 1'b1);
    check("both_din_kept", dmem_din, 64'hFFFF_DFFF_0000_2000);
    tick();
    dmem_rstrobe = 0; dmem_wstrobe = 0;
    tick();

    // Fetch cancelled while its ack is delayed; a load waits behind it.
    ack_delay = 5; imem_addr = 64'h500; imem_addr_valid = 1;
    tick();
    n_cyc = mem_req ? 1 : 0;
    tick();
    imem_addr_valid = 0; dmem_rstrobe = 1; dmem_addr = 64'h3000; dmem_write_width = 2'd3;
    while (mem_req && n_cyc < 40) begin n_cyc++; tick(); end
    check("cancel_req_cycles", 64'(n_cyc), 64'd6);
    check("cancel_no_pulse", imem_data_valid, 1'b0);
    check("cancel_idata", imem_data, 64'hFFFF_FAFF_0000_0500);
    ack_delay = 0;
    wait_req("cancel_next_grant");
    check("cancel_next_addr", mem_addr, 64'h3000);
    check("cancel_next_we", mem_we, 1'b0);
    wait_req_low("cancel_next_end");
    check("cancel_next_pulse", dmem_cycle_complete, 1'b1);
    check("cancel_next_din", dmem_din, 64'hFFFF_CFFF_0000_3000);
    tick();
    dmem_rstrobe = 0;
    tick();

    // Reset asserted in the middle of a bus cycle.
    ack_delay = 20; dmem_rstrobe = 1; dmem_addr = 64'h4000;
    tick(); tick(); tick();
    check("rstmid_req_before", mem_req, 1'b1);
    #2;
    rst = 1; dmem_rstrobe = 0;
    #1;
    check("rstmid_req_async", mem_req, 1'b0);
    tick(); tick();
    rst = 0; ack_delay = 0;
    check("rstmid_mem_addr", mem_addr, 64'h0);
    check("rstmid_mem_width", mem_width, 2'd0);
    check("rstmid_imem_data", imem_data, 64'h0);
    check("rstmid_dmem_din", dmem_din, 64'h0);
    check("rstmid_cc", dmem_cycle_complete, 1'b0);
    tick();
    dmem_rstrobe = 1; dmem_addr = 64'h4000;
    wait_req("post_rst_grant");
    check("post_rst_addr", mem_addr, 64'h4000);
    wait_req_low("post_rst_end");
    check("post_rst_pulse", dmem_cycle_complete, 1'b1);
    tick();
    dmem_rstrobe = 0;
    tick();

    // Watchdog instance: one normal load, then a load that is never acked.
    t_rstrobe = 1; t_daddr = 64'h700;
    tick();
    check("t_req_on", t_req, 1'b1);
    check("t_addr", t_maddr, 64'h700);
    tick();
    t_ack = 1; t_rdata = 64'h1234;
    tick();
    t_ack = 0; t_rdata = '0;
    check("t_load_pulse", t_cc, 1'b1);
    check("t_load_din", t_din, 64'h1234);
    check("t_no_error_yet", t_err, 1'b0);
    tick();
    t_rstrobe = 0;
    tick();
    t_rstrobe = 1; t_daddr = 64'h708;
    tick();
    n_cyc = 0;
    while (t_req && n_cyc < 20) begin n_cyc++; tick(); end
    check("t_req_cycles", 64'(n_cyc), 64'(T_SHORT));
    check("t_timeout_pulse", t_cc, 1'b1);
    check("t_timeout_din", t_din, 64'h0);
    check("t_error_set", t_err, 1'b1);
    t_ack = 1; t_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    t_ack = 0; t_rdata = '0; t_rstrobe = 0;
    check("t_late_ack_no_req", t_req, 1'b0);
    check("t_late_ack_no_pulse", t_cc, 1'b0);
    check("t_late_ack_din", t_din, 64'h0);
    check("t_error_sticky", t_err, 1'b1);
    tick(); tick();
    check("t_idle_no_req", t_req, 1'b0);
    check("t_no_fetch_pulse", t_ivld, 1'b0);
    check("t_error_still", t_err, 1'b1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
